tl_a_queue_param: RTL



---
 rtl/tl_a_queue_pkg.sv | 27 ++
 rtl/tl_a_queue_wrap_ptr.sv | 35 +++
 rtl/tl_a_queue_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/tl_a_queue_pkg.sv
// -----------------------------------------------------------------------------
// tl_a_queue_pkg
// Shared TileLink A-channel definitions for the parametrised A queue:
//   - tl_a_opcode_e : A-channel opcode encodings (3 bits)
//   - TL_PARAM_W    : width of the A-channel param field
//   - cnt_w()       : width of an occupancy counter able to hold 0..depth
// No ports (package).
// -----------------------------------------------------------------------------
package tl_a_queue_pkg;

   typedef enum logic [2:0] {
      TL_PUT_FULL    = 3'd0,
      TL_PUT_PARTIAL = 3'd1,
      TL_ARITH       = 3'd2,
      TL_LOGIC       = 3'd3,
      TL_GET         = 3'd4,
      TL_HINT        = 3'd5
   } tl_a_opcode_e;

   localparam int TL_PARAM_W = 3;

   // Occupancy spans 0..depth inclusive, hence depth+1 distinct values.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/tl_a_queue_wrap_ptr.sv
// -----------------------------------------------------------------------------
// tl_a_queue_wrap_ptr
// Modulo-DEPTH pointer: advances by one when i_adv is high and wraps from
// DEPTH-1 back to 0 explicitly, so DEPTH need not be a power of two.
// Ports:
//   i_clk  in   clock
//   i_rst  in   asynchronous active-high reset (pointer -> 0)
//   i_adv  in   advance enable
//   o_ptr  out  current pointer value, PTR_W bits
// -----------------------------------------------------------------------------
module tl_a_queue_wrap_ptr
   import tl_a_queue_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PTR_W = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_adv,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= (r_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/tl_a_queue_param.sv
// -----------------------------------------------------------------------------
// tl_a_queue_param
// Parametrised TileLink A-channel FIFO (Get-style beats, no data field) used
// as a decoupling/timing buffer between a requesting client and the crossbar.
// Optional FLOW (empty-queue bypass) and PIPE (enq while full and draining).
// Optional checkers: define TL_A_QUEUE_ASSERT_EN to compile protocol
// assertions; without it no checker logic exists.
// Ports:
//   clock, reset             clock; asynchronous active-high reset
//   io_enq_valid/ready       enqueue handshake
//   io_enq_bits_*            opcode(3) param(3) size source address mask corrupt
//   io_deq_ready/valid       dequeue handshake
//   io_deq_bits_*            head entry (combinational read)
//   io_count                 current occupancy, $clog2(DEPTH+1) bits
// -----------------------------------------------------------------------------
module tl_a_queue_param
   import tl_a_queue_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int SIZE_W   = 4,
   parameter int SOURCE_W = 7,
   parameter int ADDR_W   = 14,
   parameter int MASK_W   = 8,
   parameter int FLOW     = 0,
   parameter int PIPE     = 0,
   localparam int CNT_W   = cnt_w(DEPTH),
   localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  io_enq_valid,
   output logic                  io_enq_ready,
   input  logic [2:0]            io_enq_bits_opcode,
   input  logic [TL_PARAM_W-1:0] io_enq_bits_param,
   input  logic [SIZE_W-1:0]     io_enq_bits_size,
   input  logic [SOURCE_W-1:0]   io_enq_bits_source,
   input  logic [ADDR_W-1:0]     io_enq_bits_address,
   input  logic [MASK_W-1:0]     io_enq_bits_mask,
   input  logic                  io_enq_bits_corrupt,
   input  logic                  io_deq_ready,
   output logic                  io_deq_valid,
   output logic [2:0]            io_deq_bits_opcode,
   output logic [TL_PARAM_W-1:0] io_deq_bits_param,
   output logic [SIZE_W-1:0]     io_deq_bits_size,
   output logic [SOURCE_W-1:0]   io_deq_bits_source,
   output logic [ADDR_W-1:0]     io_deq_bits_address,
   output logic [MASK_W-1:0]     io_deq_bits_mask,
   output logic                  io_deq_bits_corrupt,
   output logic [CNT_W-1:0]      io_count
);

   typedef struct packed {
      logic [2:0]            opcode;
      logic [TL_PARAM_W-1:0] param;
      logic [SIZE_W-1:0]     size;
      logic [SOURCE_W-1:0]   source;
      logic [ADDR_W-1:0]     address;
      logic [MASK_W-1:0]     mask;
      logic                  corrupt;
   } entry_t;

   entry_t           r_mem [DEPTH];
   logic             r_maybe_full;
   logic [PTR_W-1:0] w_enq_ptr;
   logic [PTR_W-1:0] w_deq_ptr;
   logic             w_ptr_match;
   logic             w_empty;
   logic             w_full;
   logic             w_flow_byp;
   logic             w_do_enq;
   logic             w_do_deq;
   entry_t           w_enq_entry;
   entry_t           w_deq_entry;
   logic [CNT_W-1:0] w_enq_ext;
   logic [CNT_W-1:0] w_deq_ext;

   assign w_enq_entry = '{opcode:  io_enq_bits_opcode,
                          param:   io_enq_bits_param,
                          size:    io_enq_bits_size,
                          source:  io_enq_bits_source,
                          address: io_enq_bits_address,
                          mask:    io_enq_bits_mask,
                          corrupt: io_enq_bits_corrupt};

   tl_a_queue_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_enq_ptr (
      .i_clk (clock),
      .i_rst (reset),
      .i_adv (w_do_enq),
      .o_ptr (w_enq_ptr)
   );

   tl_a_queue_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_deq_ptr (
      .i_clk (clock),
      .i_rst (reset),
      .i_adv (w_do_deq),
      .o_ptr (w_deq_ptr)
   );

   assign w_ptr_match = (w_enq_ptr == w_deq_ptr);
   assign w_empty     = w_ptr_match & ~r_maybe_full;
   assign w_full      = w_ptr_match &  r_maybe_full;

   // In FLOW mode an empty queue hands the incoming beat straight to the
   // consumer; when the consumer takes it, storage is left untouched.
   assign w_flow_byp = (FLOW != 0) & w_empty & io_deq_ready;

   always_comb begin
      io_enq_ready = ~w_full;
      if (PIPE != 0) io_enq_ready = ~w_full | io_deq_ready;
      io_deq_valid = ~w_empty;
      w_deq_entry  = r_mem[w_deq_ptr];
      if ((FLOW != 0) && w_empty) begin
         io_deq_valid = io_enq_valid;
         w_deq_entry  = w_enq_entry;
      end
   end

   assign w_do_enq = io_enq_valid & io_enq_ready & ~w_flow_byp;
   assign w_do_deq = io_deq_ready & io_deq_valid & ~w_flow_byp;

   // Payload storage carries no reset: contents are meaningless until the
   // pointers say an entry is live.
   always_ff @(posedge clock) begin
      if (w_do_enq) r_mem[w_enq_ptr] <= w_enq_entry;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_maybe_full <= 1'b0;
      end else if (w_do_enq != w_do_deq) begin
         r_maybe_full <= w_do_enq;
      end
   end

   assign io_deq_bits_opcode  = w_deq_entry.opcode;
   assign io_deq_bits_param   = w_deq_entry.param;
   assign io_deq_bits_size    = w_deq_entry.size;
   assign io_deq_bits_source  = w_deq_entry.source;
   assign io_deq_bits_address = w_deq_entry.address;
   assign io_deq_bits_mask    = w_deq_entry.mask;
   assign io_deq_bits_corrupt = w_deq_entry.corrupt;

   // Occupancy = (enq - deq) mod DEPTH; the wrap case adds DEPTH back in,
   // and matching pointers are disambiguated by maybe_full.
   assign w_enq_ext = CNT_W'(w_enq_ptr);
   assign w_deq_ext = CNT_W'(w_deq_ptr);

   always_comb begin
      if (w_full)                     io_count = CNT_W'(DEPTH);
      else if (w_enq_ptr < w_deq_ptr) io_count = w_enq_ext + CNT_W'(DEPTH) - w_deq_ext;
      else                            io_count = w_enq_ext - w_deq_ext;
   end

`ifdef TL_A_QUEUE_ASSERT_EN
   if (DEPTH < 1) begin : g_depth_chk
      $error("tl_a_queue_param: DEPTH must be >= 1");
   end

   a_enq_valid_hold : assert property (@(posedge clock) disable iff (reset)
      io_enq_valid && !io_enq_ready |=> io_enq_valid);

   a_enq_bits_stable : assert property (@(posedge clock) disable iff (reset)
      io_enq_valid && !io_enq_ready |=> $stable(w_enq_entry));

   a_count_bound : assert property (@(posedge clock) disable iff (reset)
      io_count <= CNT_W'(DEPTH));

   a_no_enq_full : assert property (@(posedge clock) disable iff (reset)
      w_full && w_do_enq |-> (PIPE != 0) && io_deq_ready);
`endif

endmodule
